// File: rtl/td4_disp_pkg.sv
// Shared constants and types for the TD4 register-display snapshot block.
// Build option: TD4_CHG_HILITE_EN enables per-row change flags in td4_reg_snapshot.
package td4_disp_pkg;

   localparam int NREG_DEF = 8;   // displayed register rows
   localparam int DW_DEF   = 4;   // bits per register row
   localparam int AW_DEF   = 3;   // row address width
   localparam int FCNT_W   = 8;   // committed-swap counter width

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SWAP = 1'b1
   } state_t;

endpackage

// File: rtl/td4_reg_snapshot_vsync_fall_det.sv
// Falling-edge detector for the active-low VSYNC from the display timing generator.
// The delayed copy resets to 1 so that a low VSYNC present at reset release still
// produces one frame-start pulse.
module vsync_fall_det (
   input  logic CLK,
   input  logic RST,
   input  logic frame_sync,
   output logic vs_fall
);

   logic vs_d;

   // Delay VSYNC by one pixel clock for edge detection
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) vs_d <= 1'b1;
      else     vs_d <= frame_sync;
   end

   assign vs_fall = vs_d & ~frame_sync;

endmodule

// File: rtl/td4_reg_snapshot.sv
// TD4 register snapshot: CPU writes a staging bank at any time; the whole bank is
// copied to the display bank in one cycle right after VSYNC falls, so a frame never
// shows a half-updated register set.
// Build option: TD4_CHG_HILITE_EN adds per-row "changed at last swap" flags on regchg;
// without it regchg is tied low and the port list is unchanged.
module td4_reg_snapshot
   import td4_disp_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int DW   = DW_DEF,
   parameter int AW   = AW_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DW-1:0]     wr_data,
   output logic              wr_ready,
   input  logic              frame_sync,
   input  logic              freeze,
   input  logic [AW-1:0]     regsel,
   output logic [DW-1:0]     regdat,
   output logic              regchg,
   output logic              swap_pulse,
   output logic [FCNT_W-1:0] frame_cnt
);

   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] staging [NREG];
   logic [DW-1:0] display [NREG];
   logic          dirty;
   logic          vs_fall;
   logic          wr_acc;
   logic          wr_in_range;
   logic          sel_in_range;
   logic          in_swap;

   vsync_fall_det u_vsync_fall_det (
      .CLK        (CLK),
      .RST        (RST),
      .frame_sync (frame_sync),
      .vs_fall    (vs_fall)
   );

   // Out-of-range writes still complete the handshake but touch nothing
   assign wr_acc       = wr_en && wr_ready;
   assign wr_in_range  = 32'(wr_addr) < NREG;
   assign sel_in_range = 32'(regsel) < NREG;
   assign in_swap      = (state == ST_SWAP);

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: swap only on frame start with pending data and no freeze
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (vs_fall && dirty && !freeze) state_nxt = ST_SWAP;
         ST_SWAP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: writes are refused only during the single copy cycle
   always_comb begin
      wr_ready   = (state == ST_IDLE);
      swap_pulse = (state == ST_SWAP);
   end

   // Staging bank: CPU-side row writes
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NREG; i++) staging[i] <= '0;
      end else if (wr_acc && wr_in_range) begin
         staging[wr_addr] <= wr_data;
      end
   end

   // Display bank: parallel copy of every row in the swap cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NREG; i++) display[i] <= '0;
      end else if (in_swap) begin
         for (int i = 0; i < NREG; i++) display[i] <= staging[i];
      end
   end

   // Dirty flag: set by an in-range write, cleared by the copy (no writes land in SWAP)
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                        dirty <= 1'b0;
      else if (in_swap)               dirty <= 1'b0;
      else if (wr_acc && wr_in_range) dirty <= 1'b1;
   end

   // Committed-swap counter, wraps naturally
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)          frame_cnt <= '0;
      else if (in_swap) frame_cnt <= frame_cnt + 1'b1;
   end

   // Display read port: zero latency, rows beyond NREG read as zero
   always_comb begin
      regdat = '0;
      if (sel_in_range) regdat = display[regsel];
   end

`ifdef TD4_CHG_HILITE_EN
   logic [NREG-1:0] chg;

   // Change flags: compare old and new row contents at the copy, hold until next copy
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         chg <= '0;
      end else if (in_swap) begin
         for (int i = 0; i < NREG; i++) chg[i] <= (staging[i] != display[i]);
      end
   end

   assign regchg = sel_in_range ? chg[regsel] : 1'b0;
`else
   assign regchg = 1'b0;
`endif

endmodule
